// File: rtl/mem_req_arbiter_pkg.sv
// Shared memory-port types for the icache/dcache request arbiter.
// Tags 1..15 identify outstanding loads; tag 0 means none.
package mem_req_arbiter_pkg;

    typedef logic [3:0] MEM_TAG;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } MEM_OWNER;

    typedef struct packed {
        logic        valid;
        MEM_OWNER    owner;
        logic [31:0] addr;
        logic        squashed;
    } MEM_TAG_ENTRY;

    localparam int NUM_TAGS            = 15;
    localparam int DEF_STARVE_LIMIT    = 4;
    localparam int DEF_MAX_OUTSTANDING = 15;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load table indexed by memory tag: allocate, clear on
// response, squash icache fills on flush, and report live count.
module mem_tag_table
    import mem_req_arbiter_pkg::*;
(
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_alloc_en,
    input  MEM_TAG       i_alloc_tag,
    input  MEM_OWNER     i_alloc_owner,
    input  logic [31:0]  i_alloc_addr,
    input  MEM_TAG       i_clr_tag,
    input  logic         i_squash_ic,
    output MEM_TAG_ENTRY o_rd_entry,
    output logic [4:0]   o_live_cnt,
    output logic         o_busy
);

    MEM_TAG_ENTRY r_tab [1:NUM_TAGS];
    MEM_TAG_ENTRY w_nxt [1:NUM_TAGS];

    // Clear-then-set ordering lets a same-tag allocation survive a response.
    always_comb begin
        o_rd_entry = '0;
        o_live_cnt = '0;
        for (int i = 1; i <= NUM_TAGS; i++) begin
            w_nxt[i] = r_tab[i];
            if (r_tab[i].valid) begin
                o_live_cnt = o_live_cnt + 5'd1;
            end
            if (i_clr_tag == MEM_TAG'(i)) begin
                o_rd_entry     = r_tab[i];
                w_nxt[i].valid = 1'b0;
            end
            if (i_alloc_en && (i_alloc_tag == MEM_TAG'(i))) begin
                w_nxt[i].valid    = 1'b1;
                w_nxt[i].owner    = i_alloc_owner;
                w_nxt[i].addr     = i_alloc_addr;
                w_nxt[i].squashed = 1'b0;
            end
            if (i_squash_ic && w_nxt[i].valid &&
                (w_nxt[i].owner == OWN_IC)) begin
                w_nxt[i].squashed = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (i_reset) begin
                r_tab[i] <= '0;
            end else begin
                r_tab[i] <= w_nxt[i];
            end
        end
    end

    assign o_busy = (o_live_cnt != 5'd0);

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates the main-memory command port between icache fills and
// dcache requests, and routes returning blocks to the owning cache.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT    = DEF_STARVE_LIMIT,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        ic_req_valid,
    input  logic [31:0] ic_req_addr,
    output logic        ic_req_ready,
    input  logic        dc_req_valid,
    input  MEM_COMMAND  dc_req_cmd,
    input  logic [31:0] dc_req_addr,
    input  logic [63:0] dc_req_data,
    output logic        dc_req_ready,
    output MEM_COMMAND  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    input  MEM_TAG      mem2proc_transaction_tag,
    input  logic [63:0] mem2proc_data,
    input  MEM_TAG      mem2proc_data_tag,
    output logic        ic_resp_valid,
    output logic [31:0] ic_resp_addr,
    output logic [63:0] ic_resp_data,
    output logic        dc_resp_valid,
    output logic [31:0] dc_resp_addr,
    output logic [63:0] dc_resp_data,
    output logic        busy
);

    logic [7:0]   r_starve_cnt;
    logic         r_ic_resp_valid;
    logic [31:0]  r_ic_resp_addr;
    logic [63:0]  r_ic_resp_data;
    logic         r_dc_resp_valid;
    logic [31:0]  r_dc_resp_addr;
    logic [63:0]  r_dc_resp_data;

    logic         w_full;
    logic         w_ic_ok;
    logic         w_dc_ok;
    logic         w_ic_prio;
    logic         w_gnt_ic;
    logic         w_gnt_dc;
    logic         w_tag_ok;
    logic         w_alloc;
    MEM_OWNER     w_alloc_owner;
    logic [31:0]  w_alloc_addr;
    MEM_TAG_ENTRY w_rd;
    logic [4:0]   w_live_cnt;

    // Full check uses the registered count, so a same-cycle free
    // does not open a slot until the next cycle.
    always_comb begin
        w_full    = (32'(w_live_cnt) >= MAX_OUTSTANDING);
        w_ic_ok   = !reset && ic_req_valid && !flush && !w_full;
        w_dc_ok   = !reset && dc_req_valid &&
                    ((dc_req_cmd == MEM_STORE) ||
                     ((dc_req_cmd == MEM_LOAD) && !w_full));
        w_ic_prio = (32'(r_starve_cnt) == STARVE_LIMIT);
        w_gnt_ic  = w_ic_ok && (w_ic_prio || !w_dc_ok);
        w_gnt_dc  = w_dc_ok && !w_gnt_ic;
        w_tag_ok  = (mem2proc_transaction_tag != '0);

        ic_req_ready = w_gnt_ic && w_tag_ok;
        dc_req_ready = w_gnt_dc && w_tag_ok;

        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (w_gnt_ic) begin
            proc2mem_command = MEM_LOAD;
            proc2mem_addr    = ic_req_addr;
        end else if (w_gnt_dc) begin
            proc2mem_command = dc_req_cmd;
            proc2mem_addr    = dc_req_addr;
            proc2mem_data    = dc_req_data;
        end

        w_alloc       = ic_req_ready ||
                        (dc_req_ready && (dc_req_cmd == MEM_LOAD));
        w_alloc_owner = ic_req_ready ? OWN_IC : OWN_DC;
        w_alloc_addr  = ic_req_ready ? ic_req_addr : dc_req_addr;
    end

    mem_tag_table u_tag_table (
        .i_clock       (clock),
        .i_reset       (reset),
        .i_alloc_en    (w_alloc),
        .i_alloc_tag   (mem2proc_transaction_tag),
        .i_alloc_owner (w_alloc_owner),
        .i_alloc_addr  (w_alloc_addr),
        .i_clr_tag     (mem2proc_data_tag),
        .i_squash_ic   (flush),
        .o_rd_entry    (w_rd),
        .o_live_cnt    (w_live_cnt),
        .o_busy        (busy)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (!ic_req_valid || ic_req_ready) begin
            r_starve_cnt <= '0;
        end else if (32'(r_starve_cnt) < STARVE_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ic_resp_valid <= 1'b0;
            r_ic_resp_addr  <= '0;
            r_ic_resp_data  <= '0;
            r_dc_resp_valid <= 1'b0;
            r_dc_resp_addr  <= '0;
            r_dc_resp_data  <= '0;
        end else begin
            r_ic_resp_valid <= 1'b0;
            r_ic_resp_addr  <= '0;
            r_ic_resp_data  <= '0;
            r_dc_resp_valid <= 1'b0;
            r_dc_resp_addr  <= '0;
            r_dc_resp_data  <= '0;
            if ((mem2proc_data_tag != '0) && w_rd.valid && !w_rd.squashed) begin
                if (w_rd.owner == OWN_IC) begin
                    r_ic_resp_valid <= 1'b1;
                    r_ic_resp_addr  <= w_rd.addr;
                    r_ic_resp_data  <= mem2proc_data;
                end else begin
                    r_dc_resp_valid <= 1'b1;
                    r_dc_resp_addr  <= w_rd.addr;
                    r_dc_resp_data  <= mem2proc_data;
                end
            end
        end
    end

    assign ic_resp_valid = r_ic_resp_valid;
    assign ic_resp_addr  = r_ic_resp_addr;
    assign ic_resp_data  = r_ic_resp_data;
    assign dc_resp_valid = r_dc_resp_valid;
    assign dc_resp_addr  = r_dc_resp_addr;
    assign dc_resp_data  = r_dc_resp_data;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: priority, starvation, flush,
// full table, tag collision, tag-0 retry and reset behaviour.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready;
    logic        dc_req_valid;
    MEM_COMMAND  dc_req_cmd;
    logic [31:0] dc_req_addr;
    logic [63:0] dc_req_data;
    logic        dc_req_ready;
    MEM_COMMAND  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    MEM_TAG      mem2proc_transaction_tag;
    logic [63:0] mem2proc_data;
    MEM_TAG      mem2proc_data_tag;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_addr;
    logic [63:0] ic_resp_data;
    logic        dc_resp_valid;
    logic [31:0] dc_resp_addr;
    logic [63:0] dc_resp_data;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    mem_req_arbiter dut (
        .clock                    (clock),
        .reset                    (reset),
        .flush                    (flush),
        .ic_req_valid             (ic_req_valid),
        .ic_req_addr              (ic_req_addr),
        .ic_req_ready             (ic_req_ready),
        .dc_req_valid             (dc_req_valid),
        .dc_req_cmd               (dc_req_cmd),
        .dc_req_addr              (dc_req_addr),
        .dc_req_data              (dc_req_data),
        .dc_req_ready             (dc_req_ready),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .proc2mem_data            (proc2mem_data),
        .mem2proc_transaction_tag (mem2proc_transaction_tag),
        .mem2proc_data            (mem2proc_data),
        .mem2proc_data_tag        (mem2proc_data_tag),
        .ic_resp_valid            (ic_resp_valid),
        .ic_resp_addr             (ic_resp_addr),
        .ic_resp_data             (ic_resp_data),
        .dc_resp_valid            (dc_resp_valid),
        .dc_resp_addr             (dc_resp_addr),
        .dc_resp_data             (dc_resp_data),
        .busy                     (busy)
    );

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle();
        flush                    = 1'b0;
        ic_req_valid             = 1'b0;
        ic_req_addr              = '0;
        dc_req_valid             = 1'b0;
        dc_req_cmd               = MEM_NONE;
        dc_req_addr              = '0;
        dc_req_data              = '0;
        mem2proc_transaction_tag = '0;
        mem2proc_data            = '0;
        mem2proc_data_tag        = '0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        ic_req_valid = 1'b1; ic_req_addr = 32'h40;
        dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD;
        dc_req_addr = 32'h80; dc_req_data = 64'h1;
        mem2proc_transaction_tag = 4'd3; mem2proc_data_tag = 4'd3;
        #1;
        n_tests++;
        if ({ic_req_ready, dc_req_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_ready: got %b want 00", {ic_req_ready, dc_req_ready});
        end
        n_tests++;
        if (proc2mem_command !== MEM_NONE || proc2mem_addr !== 32'h0 || proc2mem_data !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_proc2mem: got cmd=%0d addr=%h data=%h want 0/0/0",
                     proc2mem_command, proc2mem_addr, proc2mem_data);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0 ||
            dc_resp_addr !== 32'h0 || ic_resp_data !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_state: got busy=%b icv=%b dcv=%b want 0/0/0",
                     busy, ic_resp_valid, dc_resp_valid);
        end
        idle();
        reset = 1'b0;
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy_after: got %b want 0", busy);
        end
    endtask

    task automatic test_dc_priority();
        tick(); idle();
        ic_req_valid = 1'b1; ic_req_addr = 32'h100;
        dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD; dc_req_addr = 32'h200;
        mem2proc_transaction_tag = 4'd3;
        #1;
        n_tests++;
        if (dc_req_ready !== 1'b1 || ic_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_ready: got dc=%b ic=%b want 1/0", dc_req_ready, ic_req_ready);
        end
        n_tests++;
        if (proc2mem_command !== MEM_LOAD || proc2mem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL prio_cmd: got %0d/%h want 1/00000200", proc2mem_command, proc2mem_addr);
        end
        tick(); idle();
        mem2proc_data_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF_0000_0003;
        tick();
        n_tests++;
        if (dc_resp_valid !== 1'b1 || dc_resp_addr !== 32'h200 ||
            dc_resp_data !== 64'hDEAD_BEEF_0000_0003 || ic_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_resp: got v=%b a=%h d=%h icv=%b want 1/200/deadbeef00000003/0",
                     dc_resp_valid, dc_resp_addr, dc_resp_data, ic_resp_valid);
        end
        idle();
        tick();
        n_tests++;
        if (dc_resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_resp_drop: got v=%b busy=%b want 0/0", dc_resp_valid, busy);
        end
    endtask

    task automatic test_starvation();
        int bad = 0;
        for (int c = 1; c <= 4; c++) begin
            tick(); idle();
            ic_req_valid = 1'b1; ic_req_addr = 32'h300;
            dc_req_valid = 1'b1; dc_req_cmd = MEM_STORE;
            dc_req_addr = 32'h400; dc_req_data = 64'h55;
            mem2proc_transaction_tag = 4'd1;
            #1;
            if (dc_req_ready !== 1'b1 || ic_req_ready !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL starve_dc_wins: got %0d bad cycles want 0", bad);
        end
        tick();
        #1;
        n_tests++;
        if (ic_req_ready !== 1'b1 || dc_req_ready !== 1'b0 ||
            proc2mem_command !== MEM_LOAD || proc2mem_addr !== 32'h300) begin
            n_fail++;
            $display("FAIL starve_ic_wins: got ic=%b dc=%b cmd=%0d a=%h want 1/0/1/300",
                     ic_req_ready, dc_req_ready, proc2mem_command, proc2mem_addr);
        end
        tick();
        ic_req_addr = 32'h308;
        #1;
        n_tests++;
        if (dc_req_ready !== 1'b1 || ic_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_cleared: got dc=%b ic=%b want 1/0", dc_req_ready, ic_req_ready);
        end
        tick(); idle();
        mem2proc_data_tag = 4'd1; mem2proc_data = 64'h1111;
        tick();
        n_tests++;
        if (ic_resp_valid !== 1'b1 || ic_resp_addr !== 32'h300 ||
            ic_resp_data !== 64'h1111 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_resp: got v=%b a=%h d=%h busy=%b want 1/300/1111/0",
                     ic_resp_valid, ic_resp_addr, ic_resp_data, busy);
        end
        idle();
    endtask

    task automatic test_flush();
        tick(); idle();
        ic_req_valid = 1'b1; ic_req_addr = 32'h1000;
        mem2proc_transaction_tag = 4'd5;
        #1;
        n_tests++;
        if (ic_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ic_alloc: got %b want 1", ic_req_ready);
        end
        tick(); idle();
        dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD; dc_req_addr = 32'h2000;
        mem2proc_transaction_tag = 4'd8;
        tick(); idle();
        flush = 1'b1;
        ic_req_valid = 1'b1; ic_req_addr = 32'h1008;
        mem2proc_transaction_tag = 4'd6;
        #1;
        n_tests++;
        if (ic_req_ready !== 1'b0 || proc2mem_command !== MEM_NONE) begin
            n_fail++;
            $display("FAIL flush_no_ic_grant: got rdy=%b cmd=%0d want 0/0",
                     ic_req_ready, proc2mem_command);
        end
        tick(); idle();
        mem2proc_data_tag = 4'd5; mem2proc_data = 64'h5555;
        tick();
        n_tests++;
        if (ic_resp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_squashed: got icv=%b busy=%b want 0/1", ic_resp_valid, busy);
        end
        idle();
        mem2proc_data_tag = 4'd8; mem2proc_data = 64'h8888;
        tick();
        n_tests++;
        if (dc_resp_valid !== 1'b1 || dc_resp_addr !== 32'h2000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_dc_kept: got v=%b a=%h busy=%b want 1/2000/0",
                     dc_resp_valid, dc_resp_addr, busy);
        end
        idle();
    endtask

    task automatic test_full();
        int bad  = 0;
        int good = 0;
        for (int i = 1; i <= 15; i++) begin
            tick(); idle();
            dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD;
            dc_req_addr = 32'(i * 16);
            mem2proc_transaction_tag = MEM_TAG'(i);
            #1;
            if (dc_req_ready !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL full_fill: got %0d rejected want 0", bad);
        end
        tick(); idle();
        dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD; dc_req_addr = 32'hA00;
        ic_req_valid = 1'b1; ic_req_addr = 32'hB00;
        mem2proc_transaction_tag = 4'd9;
        #1;
        n_tests++;
        if (dc_req_ready !== 1'b0 || ic_req_ready !== 1'b0 || proc2mem_command !== MEM_NONE) begin
            n_fail++;
            $display("FAIL full_block_load: got dc=%b ic=%b cmd=%0d want 0/0/0",
                     dc_req_ready, ic_req_ready, proc2mem_command);
        end
        tick(); idle();
        dc_req_valid = 1'b1; dc_req_cmd = MEM_STORE;
        dc_req_addr = 32'hC00; dc_req_data = 64'hCAFE;
        mem2proc_transaction_tag = 4'd9;
        #1;
        n_tests++;
        if (dc_req_ready !== 1'b1 || proc2mem_command !== MEM_STORE ||
            proc2mem_addr !== 32'hC00 || proc2mem_data !== 64'hCAFE) begin
            n_fail++;
            $display("FAIL full_store: got rdy=%b cmd=%0d a=%h d=%h want 1/2/c00/cafe",
                     dc_req_ready, proc2mem_command, proc2mem_addr, proc2mem_data);
        end
        tick(); idle();
        mem2proc_data_tag = 4'd4;
        dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD; dc_req_addr = 32'h40;
        mem2proc_transaction_tag = 4'd4;
        #1;
        n_tests++;
        if (dc_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_same_cycle_free: got %b want 0", dc_req_ready);
        end
        tick();
        n_tests++;
        if (dc_resp_valid !== 1'b1 || dc_resp_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL full_free_resp: got v=%b a=%h want 1/40", dc_resp_valid, dc_resp_addr);
        end
        idle();
        dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD; dc_req_addr = 32'h40;
        mem2proc_transaction_tag = 4'd4;
        #1;
        n_tests++;
        if (dc_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_unblocked: got %b want 1", dc_req_ready);
        end
        tick(); idle();
        mem2proc_data_tag = 4'd1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (dc_resp_valid === 1'b1 && dc_resp_addr === 32'(i * 16)) good++;
            mem2proc_data_tag = (i < 15) ? MEM_TAG'(i + 1) : MEM_TAG'(0);
        end
        n_tests++;
        if (good != 15 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drain: got %0d resp busy=%b want 15/0", good, busy);
        end
        idle();
    endtask

    task automatic test_collision();
        tick(); idle();
        dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD; dc_req_addr = 32'h500;
        mem2proc_transaction_tag = 4'd2;
        tick(); idle();
        ic_req_valid = 1'b1; ic_req_addr = 32'h600;
        mem2proc_transaction_tag = 4'd2;
        mem2proc_data_tag = 4'd2; mem2proc_data = 64'hD1;
        #1;
        n_tests++;
        if (ic_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_alloc: got %b want 1", ic_req_ready);
        end
        tick();
        n_tests++;
        if (dc_resp_valid !== 1'b1 || dc_resp_addr !== 32'h500 || dc_resp_data !== 64'hD1 ||
            ic_resp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_old_owner: got dcv=%b a=%h d=%h icv=%b busy=%b want 1/500/d1/0/1",
                     dc_resp_valid, dc_resp_addr, dc_resp_data, ic_resp_valid, busy);
        end
        idle();
        mem2proc_data_tag = 4'd2; mem2proc_data = 64'hD2;
        tick();
        n_tests++;
        if (ic_resp_valid !== 1'b1 || ic_resp_addr !== 32'h600 || ic_resp_data !== 64'hD2 ||
            dc_resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_new_owner: got icv=%b a=%h d=%h dcv=%b busy=%b want 1/600/d2/0/0",
                     ic_resp_valid, ic_resp_addr, ic_resp_data, dc_resp_valid, busy);
        end
        idle();
    endtask

    task automatic test_tag0();
        tick(); idle();
        dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD; dc_req_addr = 32'h700;
        mem2proc_transaction_tag = 4'd0;
        #1;
        n_tests++;
        if (dc_req_ready !== 1'b0 || proc2mem_command !== MEM_LOAD) begin
            n_fail++;
            $display("FAIL tag0_reject: got rdy=%b cmd=%0d want 0/1", dc_req_ready, proc2mem_command);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tag0_no_alloc: got busy=%b want 0", busy);
        end
        mem2proc_transaction_tag = 4'd7;
        #1;
        n_tests++;
        if (dc_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tag0_retry: got %b want 1", dc_req_ready);
        end
        tick(); idle();
        mem2proc_data_tag = 4'd7; mem2proc_data = 64'h7777;
        tick();
        n_tests++;
        if (dc_resp_valid !== 1'b1 || dc_resp_addr !== 32'h700 || dc_resp_data !== 64'h7777) begin
            n_fail++;
            $display("FAIL tag0_resp: got v=%b a=%h d=%h want 1/700/7777",
                     dc_resp_valid, dc_resp_addr, dc_resp_data);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        tick(); idle();
        dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD; dc_req_addr = 32'h900;
        mem2proc_transaction_tag = 4'd9;
        tick(); idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem2proc_data_tag = 4'd9; mem2proc_data = 64'h9999;
        tick();
        n_tests++;
        if (dc_resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_drop: got v=%b busy=%b want 0/0", dc_resp_valid, busy);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_dc_priority();
        test_starvation();
        test_flush();
        test_full();
        test_collision();
        test_tag0();
        test_reset_mid();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
